// File: rtl/tank_pkg.sv
// Shared tank-game definitions: move keycodes and the per-player repeat state.
package tank_pkg;

  // USB HID usage codes for the eight move keys.
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

  // Auto-repeat channel states.
  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } chan_state_t;

  // True when code belongs to the selected player's set (p1_set=1: WASD, 0: arrows).
  function automatic logic is_move_key(input logic [7:0] code, input logic p1_set);
    if (p1_set)
      return (code == KEY_W) || (code == KEY_A) || (code == KEY_S) || (code == KEY_D);
    else
      return (code == KEY_UP) || (code == KEY_LEFT) || (code == KEY_DOWN) || (code == KEY_RIGHT);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// One player channel: picks that player's key from the HID report and emits it
// once on press, again after HOLD_FRAMES, then every REPEAT_FRAMES while held.
module key_repeat
  import tank_pkg::*;
#(
  parameter int HOLD_FRAMES   = 12,
  parameter int REPEAT_FRAMES = 6
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  input  logic        game_active,
  input  logic        p1_set,
  output logic [7:0]  key_out
);

  localparam logic [7:0] HOLD_RELOAD   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] REPEAT_RELOAD = 8'(REPEAT_FRAMES - 1);

  chan_state_t state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  lat, lat_n;
  logic [7:0]  out_n;
  logic [7:0]  sel;
  logic        sel_valid;

  // Select this player's key from the lowest-numbered slot holding one.
  always_comb begin
    sel       = KEY_NONE;
    sel_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (is_move_key(keycodes[8*i +: 8], p1_set)) begin
        sel       = keycodes[8*i +: 8];
        sel_valid = 1'b1;
      end
    end
  end

  // Next state, counter, latched code and the one-cycle emission.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    lat_n   = lat;
    out_n   = KEY_NONE;
    if (!game_active) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
      lat_n   = KEY_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_valid) begin
            out_n   = sel;
            lat_n   = sel;
            cnt_n   = HOLD_RELOAD;
            state_n = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!sel_valid) begin
            state_n = IDLE;
          end else if (sel != lat) begin
            // A different key counts as a fresh press, emitted right away.
            out_n   = sel;
            lat_n   = sel;
            cnt_n   = HOLD_RELOAD;
            state_n = HOLD;
          end else if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
          end else begin
            out_n   = lat;
            cnt_n   = REPEAT_RELOAD;
            state_n = REPEAT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and registered output; Reset aborts any pending repeat.
  always_ff @(posedge frame_clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      lat     <= KEY_NONE;
      key_out <= KEY_NONE;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lat     <= lat_n;
      key_out <= out_n;
    end
  end

endmodule

// File: rtl/keycode_dispatch.sv
// Splits a USB HID keyboard report into two independent auto-repeating move
// streams: WASD for player 1 and the arrow keys for player 2.
module keycode_dispatch
  import tank_pkg::*;
#(
  parameter int HOLD_FRAMES   = 12,
  parameter int REPEAT_FRAMES = 6
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  input  logic        game_active,
  output logic [7:0]  key_p1,
  output logic [7:0]  key_p2
);

  // Player 1 channel: WASD, feeds the tank instance with player=1.
  key_repeat #(
    .HOLD_FRAMES   (HOLD_FRAMES),
    .REPEAT_FRAMES (REPEAT_FRAMES)
  ) u_p1 (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycodes    (keycodes),
    .game_active (game_active),
    .p1_set      (1'b1),
    .key_out     (key_p1)
  );

  // Player 2 channel: arrow keys, feeds the tank instance with player=0.
  key_repeat #(
    .HOLD_FRAMES   (HOLD_FRAMES),
    .REPEAT_FRAMES (REPEAT_FRAMES)
  ) u_p2 (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycodes    (keycodes),
    .game_active (game_active),
    .p1_set      (1'b0),
    .key_out     (key_p2)
  );

endmodule

// File: tb/tb_keycode_dispatch.sv
// Self-checking bench for keycode_dispatch: a table of per-cycle vectors plus
// hand-written sequences for fast-repeat parameters and asynchronous reset.
module tb_keycode_dispatch;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [31:0] keycodes;
  logic        game_active;
  logic [7:0]  key_p1, key_p2;
  logic [7:0]  fast_p1, fast_p2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] keys;
    logic        active;
    logic [7:0]  exp_p1;
    logic [7:0]  exp_p2;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  always #5 frame_clk = ~frame_clk;

  keycode_dispatch dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycodes    (keycodes),
    .game_active (game_active),
    .key_p1      (key_p1),
    .key_p2      (key_p2)
  );

  keycode_dispatch #(.HOLD_FRAMES(1), .REPEAT_FRAMES(1)) dut_fast (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycodes    (keycodes),
    .game_active (game_active),
    .key_p1      (fast_p1),
    .key_p2      (fast_p2)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] k, input logic a, input logic [7:0] e1,
                     input logic [7:0] e2, input string t);
    vec_t v;
    v.keys = k; v.active = a; v.exp_p1 = e1; v.exp_p2 = e2; v.tag = t;
    vecs.push_back(v);
  endtask

  // Advance one frame and settle just after the rising edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;

    // ---- vector table (cycle n = output after the n-th edge of a sequence) ----
    // Hold D for 40 frames: emissions at 1, 13, 19, 25, 31, 37.
    for (int i = 1; i <= 40; i++) begin
      e = (i == 1 || i == 13 || i == 19 || i == 25 || i == 31 || i == 37) ? 8'h07 : 8'h00;
      add(32'h0000_0007, 1'b1, e, 8'h00, $sformatf("hold_D c%0d", i));
    end
    add(32'h0, 1'b1, 8'h00, 8'h00, "release_D");

    // W in slot 0 wins over A in slot 2; dropping W emits A at once and restarts hold.
    for (int i = 1; i <= 5; i++)
      add(32'h0004_001A, 1'b1, (i == 1) ? 8'h1A : 8'h00, 8'h00, $sformatf("WA c%0d", i));
    for (int i = 1; i <= 13; i++)
      add(32'h0004_0000, 1'b1, (i == 1 || i == 13) ? 8'h04 : 8'h00, 8'h00,
          $sformatf("A_after_W c%0d", i));
    add(32'h0, 1'b1, 8'h00, 8'h00, "release_A");

    // S and Up together: both channels emit and repeat in lockstep.
    for (int i = 1; i <= 20; i++) begin
      e = (i == 1 || i == 13 || i == 19) ? 8'hFF : 8'h00;
      add(32'h0000_5216, 1'b1, e & 8'h16, e & 8'h52, $sformatf("S_Up c%0d", i));
    end
    add(32'h0, 1'b1, 8'h00, 8'h00, "release_S_Up");

    // Left 3 frames, release 1, press again: emissions 4 cycles apart.
    add(32'h0000_0050, 1'b1, 8'h00, 8'h50, "left c1");
    add(32'h0000_0050, 1'b1, 8'h00, 8'h00, "left c2");
    add(32'h0000_0050, 1'b1, 8'h00, 8'h00, "left c3");
    add(32'h0,         1'b1, 8'h00, 8'h00, "left gap");
    add(32'h0000_0050, 1'b1, 8'h00, 8'h50, "left repress");
    add(32'h0,         1'b1, 8'h00, 8'h00, "release_left");

    // Unrelated code never emits; a valid key in slot 3 is still found.
    for (int i = 1; i <= 14; i++)
      add(32'h0000_002C, 1'b1, 8'h00, 8'h00, $sformatf("space c%0d", i));
    add(32'h0700_002C, 1'b1, 8'h07, 8'h00, "space_plus_D_slot3");
    add(32'h0, 1'b1, 8'h00, 8'h00, "release_slot3");

    // Same code moving between slots / duplicated is one uninterrupted key.
    add(32'h0000_0007, 1'b1, 8'h07, 8'h00, "dup c1");
    for (int i = 2; i <= 12; i++)
      add(32'h0707_0000, 1'b1, 8'h00, 8'h00, $sformatf("dup c%0d", i));
    add(32'h0707_0000, 1'b1, 8'h07, 8'h00, "dup c13");
    add(32'h0, 1'b1, 8'h00, 8'h00, "release_dup");

    // game_active drops exactly when a repeat was due; re-enable emits as new press.
    add(32'h0000_4F07, 1'b1, 8'h07, 8'h4F, "ga c1");
    for (int i = 2; i <= 12; i++)
      add(32'h0000_4F07, 1'b1, 8'h00, 8'h00, $sformatf("ga c%0d", i));
    add(32'h0000_4F07, 1'b0, 8'h00, 8'h00, "ga_off c13");
    add(32'h0000_4F07, 1'b0, 8'h00, 8'h00, "ga_off c14");
    add(32'h0000_4F07, 1'b1, 8'h07, 8'h4F, "ga_on c15");
    add(32'h0000_4F07, 1'b1, 8'h00, 8'h00, "ga_on c16");
    add(32'h0, 1'b1, 8'h00, 8'h00, "release_ga");

    // ---- reset state ----
    Reset       = 1'b1;
    keycodes    = 32'h0000_0007;
    game_active = 1'b1;
    #1;
    check("reset_p1", key_p1, 8'h00);
    check("reset_p2", key_p2, 8'h00);
    step();
    step();
    check("reset_held_p1", key_p1, 8'h00);
    check("reset_held_p2", key_p2, 8'h00);
    keycodes = 32'h0;
    #2 Reset = 1'b0;
    step();
    check("post_reset_idle_p1", key_p1, 8'h00);

    // ---- apply table ----
    foreach (vecs[i]) begin
      keycodes    = vecs[i].keys;
      game_active = vecs[i].active;
      step();
      check({vecs[i].tag, " p1"}, key_p1, vecs[i].exp_p1);
      check({vecs[i].tag, " p2"}, key_p2, vecs[i].exp_p2);
    end

    // ---- HOLD_FRAMES=1 / REPEAT_FRAMES=1: emit every frame, no underflow ----
    keycodes = 32'h0000_001A;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("fast_W c%0d", i), fast_p1, 8'h1A);
      check($sformatf("slow_W c%0d", i), key_p1, (i == 1) ? 8'h1A : 8'h00);
    end
    keycodes = 32'h0;
    step();
    check("fast_release", fast_p1, 8'h00);

    // ---- asynchronous reset mid-REPEAT while Right is held ----
    keycodes = 32'h0000_004F;
    for (int i = 1; i <= 13; i++) begin
      step();
      check($sformatf("right c%0d", i), key_p2, (i == 1 || i == 13) ? 8'h4F : 8'h00);
    end
    #2 Reset = 1'b1;
    #1;
    check("async_reset_p2", key_p2, 8'h00);
    step();
    check("reset_abort_p2", key_p2, 8'h00);
    #2 Reset = 1'b0;
    step();
    check("after_reset_press", key_p2, 8'h4F);
    step();
    check("after_reset_hold", key_p2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
